axi_shim_arbiter: RTL and testbench
===================================

# axi_shim_arbiter

Shares one AXI shim's read and write request ports among `NumPorts` requesters, such as the instruction cache, data cache and uncached bypass. Each direction has its own round-robin arbiter with a grant lock, so a request's payload stays stable until the shim grants it. The block tags each outgoing AXI ID with the requester index and routes R and B responses back by that tag. It sits directly between the cache subsystems and the shim; there is no buffering.

## Interface
- `NumPorts`, default 3: number of requesters, must be ≥2; `PW = $clog2(NumPorts)`.
- `AxiNumWords`, default 4: burst words; `BW = $clog2(AxiNumWords)`.
- `AxiIdWidth`, default 4: shim ID width; the requester ID width is `IW = AxiIdWidth-PW`, must be ≥1.
- `AxiUserWidth`, default 64: user width per word.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `p_rd_req_i`/`p_rd_gnt_o`  in/out  [NumPorts]  read request / grant.
- `p_rd_addr_i` [NumPorts][64], `p_rd_blen_i` [NumPorts][BW], `p_rd_size_i` [NumPorts][2], `p_rd_id_i` [NumPorts][IW], `p_rd_lock_i` [NumPorts]  in  read payload.
- `p_rd_rdy_i`  in  [NumPorts]; `p_rd_valid_o`, `p_rd_last_o`, `p_rd_exokay_o`  out  [NumPorts]; `p_rd_data_o` [64], `p_rd_user_o` [AxiUserWidth], `p_rd_id_o` [IW]  out  shared read response.
- `p_wr_req_i`/`p_wr_gnt_o`  in/out  [NumPorts]  write request / grant.
- `p_wr_addr_i` [64], `p_wr_data_i` [AxiNumWords][64], `p_wr_user_i` [AxiNumWords][AxiUserWidth], `p_wr_be_i` [AxiNumWords][8], `p_wr_blen_i` [BW], `p_wr_size_i` [2], `p_wr_id_i` [IW], `p_wr_lock_i` [1], `p_wr_atop_i` [6]  in  write payload, each per port.
- `p_wr_rdy_i`  in  [NumPorts]; `p_wr_valid_o`, `p_wr_exokay_o`  out  [NumPorts]; `p_wr_id_o`  out  [IW].
- `shim_rd_*` / `shim_wr_*`  mirror of the shim's request/response ports, with IDs [AxiIdWidth].

## Operation
- The read and write arbiters are independent and identical; each has states `IDLE` and `LOCKED`, a registered round-robin pointer `rr_q` [PW], and a registered owner `sel_q` [PW].
- **IDLE**
  - Winner is the first requesting port at or after `rr_q`, scanning upward modulo NumPorts.
  - The winner's payload is forwarded and `shim_*_req_o=1` in the same cycle.
  - Outgoing ID is `{winner[PW-1:0], p_*_id_i[winner]}`.
  - If the shim grants in that cycle: `p_*_gnt_o[winner]=1`, `rr_q<=winner+1` (wrapping to 0 past NumPorts-1), stay in IDLE.
  - Otherwise `sel_q<=winner` and go to LOCKED.
- **LOCKED**
  - Forward only port `sel_q`; other requests are ignored and the pointer is frozen.
  - On shim grant: `p_*_gnt_o[sel_q]=1`, `rr_q<=sel_q+1`, go to IDLE.
- A requester must hold `req` and payload until `gnt`. Dropping `req` while LOCKED is illegal; the bench asserts on it.
- At most one `p_*_gnt_o` bit is high per cycle.
- **Response routing**
  - `tag = shim_rd_id_i[AxiIdWidth-1 -: PW]`.
  - `p_rd_valid_o[tag]=shim_rd_valid_i`; all other valid bits are 0.
  - `shim_rd_rdy_o = p_rd_rdy_i[tag]`; if `tag≥NumPorts`, `shim_rd_rdy_o=1` and the beat is dropped.
  - `p_rd_id_o` is the low IW bits of the response ID.
  - Data, user, last and exokay are broadcast to all ports.
  - B responses are routed identically.
- There is no response reordering; AXI per-ID ordering is preserved because the tag is part of the ID.

## Timing
- Zero-cycle request path: requester to shim is combinational, apart from the `sel_q`/state mux.
- Grant is combinational from the shim grant.
- The response path is fully combinational.
- Reset values: state IDLE, `rr_q=0`, `sel_q=0`. With all requests low, every `shim_*_req_o` and `p_*_gnt_o` is 0.
- Reset asserted mid-transaction returns both arbiters to IDLE immediately. The shim is reset on the same `rst_ni`.
- Simultaneous read and write grants to the same or different ports are legal.
- When all ports request continuously, each port is granted once per NumPorts grants.
- A granted port re-requesting in the next cycle competes normally.

## Test plan
- Single read, port 1, `rd_id=1`, ar_ready=1 → `shim_rd_id=0x5` (PW=2), `p_rd_gnt_o=3'b010` in the same cycle, `rr_q=2`. An R beat with id 0x5 gives `p_rd_valid_o=3'b010`, `p_rd_id_o=1`.
- All three ports request writes from reset, single-beat, aw/w always ready → grants in order 0, 1, 2, 0, one per cycle.
- Port 0 write burst `blen=3`, w_ready stalls 2 cycles, port 2 requests mid-burst → payload stays on port 0 until `wr_gnt`; port 2 is granted the next cycle.
- Read to port 2 pending while the shim holds ar_ready=0 for 4 cycles, port 0 also requesting → `shim_rd_addr` stays equal to port 2's address all 4 cycles, then port 0 is granted.
- R beat with tag 3 (NumPorts=3) → `shim_rd_rdy_o=1`, no `p_rd_valid_o` bit set.
- Assert `rst_ni=0` while LOCKED → next cycle state IDLE, `rr_q=0`, all grants 0.

Source files
------------

// File: rtl/axi_shim_arbiter.sv
// Arbitrates NumPorts requesters onto one AXI shim, one round-robin arbiter per direction.
// Outgoing IDs carry the requester index so responses can be routed back by tag.

module axi_shim_rr_arb #(
    parameter  int unsigned NumPorts = 3,
    localparam int unsigned PW       = $clog2(NumPorts)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NumPorts-1:0] req,
    input  logic                shim_gnt,
    output logic                shim_req,
    output logic [PW-1:0]       idx,
    output logic [NumPorts-1:0] gnt
);
    typedef enum logic {IDLE, LOCKED} state_e;

    state_e        state_q;
    logic [PW-1:0] rr_q, sel_q, winner, nxt;
    logic          any, locked;
    int unsigned   cand;

    assign locked = (state_q == LOCKED);

    // First requester at or after rr_q; a locked owner overrides the scan.
    always_comb begin
        any    = 1'b0;
        winner = '0;
        cand   = 0;
        for (int unsigned k = 0; k < NumPorts; k++) begin
            cand = 32'(rr_q) + k;
            if (cand >= NumPorts) cand = cand - NumPorts;
            if (!any && req[cand[PW-1:0]]) begin
                any    = 1'b1;
                winner = cand[PW-1:0];
            end
        end
        idx      = locked ? sel_q : winner;
        shim_req = locked | any;
        gnt      = '0;
        if (shim_req && shim_gnt) gnt[idx] = 1'b1;
        nxt = (32'(idx) == NumPorts - 1) ? '0 : idx + PW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            rr_q    <= '0;
            sel_q   <= '0;
        end else if (locked) begin
            if (shim_gnt) begin
                state_q <= IDLE;
                rr_q    <= nxt;
            end
        end else if (any) begin
            if (shim_gnt) begin
                rr_q <= nxt;
            end else begin
                sel_q   <= winner;
                state_q <= LOCKED;
            end
        end
    end
endmodule

module axi_shim_arbiter #(
    parameter  int unsigned NumPorts     = 3,
    parameter  int unsigned AxiNumWords  = 4,
    parameter  int unsigned AxiIdWidth   = 4,
    parameter  int unsigned AxiUserWidth = 64,
    localparam int unsigned PW           = $clog2(NumPorts),
    localparam int unsigned BW           = $clog2(AxiNumWords),
    localparam int unsigned IW           = AxiIdWidth - PW
) (
    input  logic                                       clk_i,
    input  logic                                       rst_ni,
    // read requesters
    input  logic [NumPorts-1:0]                        p_rd_req_i,
    output logic [NumPorts-1:0]                        p_rd_gnt_o,
    input  logic [NumPorts-1:0][63:0]                  p_rd_addr_i,
    input  logic [NumPorts-1:0][BW-1:0]                p_rd_blen_i,
    input  logic [NumPorts-1:0][1:0]                   p_rd_size_i,
    input  logic [NumPorts-1:0][IW-1:0]                p_rd_id_i,
    input  logic [NumPorts-1:0]                        p_rd_lock_i,
    input  logic [NumPorts-1:0]                        p_rd_rdy_i,
    output logic [NumPorts-1:0]                        p_rd_valid_o,
    output logic [NumPorts-1:0]                        p_rd_last_o,
    output logic [NumPorts-1:0]                        p_rd_exokay_o,
    output logic [63:0]                                p_rd_data_o,
    output logic [AxiUserWidth-1:0]                    p_rd_user_o,
    output logic [IW-1:0]                              p_rd_id_o,
    // write requesters
    input  logic [NumPorts-1:0]                        p_wr_req_i,
    output logic [NumPorts-1:0]                        p_wr_gnt_o,
    input  logic [NumPorts-1:0][63:0]                  p_wr_addr_i,
    input  logic [NumPorts-1:0][AxiNumWords-1:0][63:0] p_wr_data_i,
    input  logic [NumPorts-1:0][AxiNumWords-1:0][AxiUserWidth-1:0] p_wr_user_i,
    input  logic [NumPorts-1:0][AxiNumWords-1:0][7:0]  p_wr_be_i,
    input  logic [NumPorts-1:0][BW-1:0]                p_wr_blen_i,
    input  logic [NumPorts-1:0][1:0]                   p_wr_size_i,
    input  logic [NumPorts-1:0][IW-1:0]                p_wr_id_i,
    input  logic [NumPorts-1:0]                        p_wr_lock_i,
    input  logic [NumPorts-1:0][5:0]                   p_wr_atop_i,
    input  logic [NumPorts-1:0]                        p_wr_rdy_i,
    output logic [NumPorts-1:0]                        p_wr_valid_o,
    output logic [NumPorts-1:0]                        p_wr_exokay_o,
    output logic [IW-1:0]                              p_wr_id_o,
    // shim read port
    output logic                                       shim_rd_req_o,
    input  logic                                       shim_rd_gnt_i,
    output logic [63:0]                                shim_rd_addr_o,
    output logic [BW-1:0]                              shim_rd_blen_o,
    output logic [1:0]                                 shim_rd_size_o,
    output logic [AxiIdWidth-1:0]                      shim_rd_id_o,
    output logic                                       shim_rd_lock_o,
    output logic                                       shim_rd_rdy_o,
    input  logic                                       shim_rd_valid_i,
    input  logic                                       shim_rd_last_i,
    input  logic                                       shim_rd_exokay_i,
    input  logic [63:0]                                shim_rd_data_i,
    input  logic [AxiUserWidth-1:0]                    shim_rd_user_i,
    input  logic [AxiIdWidth-1:0]                      shim_rd_id_i,
    // shim write port
    output logic                                       shim_wr_req_o,
    input  logic                                       shim_wr_gnt_i,
    output logic [63:0]                                shim_wr_addr_o,
    output logic [AxiNumWords-1:0][63:0]               shim_wr_data_o,
    output logic [AxiNumWords-1:0][AxiUserWidth-1:0]   shim_wr_user_o,
    output logic [AxiNumWords-1:0][7:0]                shim_wr_be_o,
    output logic [BW-1:0]                              shim_wr_blen_o,
    output logic [1:0]                                 shim_wr_size_o,
    output logic [AxiIdWidth-1:0]                      shim_wr_id_o,
    output logic                                       shim_wr_lock_o,
    output logic [5:0]                                 shim_wr_atop_o,
    output logic                                       shim_wr_rdy_o,
    input  logic                                       shim_wr_valid_i,
    input  logic                                       shim_wr_exokay_i,
    input  logic [AxiIdWidth-1:0]                      shim_wr_id_i
);
    logic [PW-1:0] rd_idx, wr_idx, rd_tag, wr_tag;

    axi_shim_rr_arb #(.NumPorts(NumPorts)) u_rd_arb (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req      (p_rd_req_i),
        .shim_gnt (shim_rd_gnt_i),
        .shim_req (shim_rd_req_o),
        .idx      (rd_idx),
        .gnt      (p_rd_gnt_o)
    );

    axi_shim_rr_arb #(.NumPorts(NumPorts)) u_wr_arb (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req      (p_wr_req_i),
        .shim_gnt (shim_wr_gnt_i),
        .shim_req (shim_wr_req_o),
        .idx      (wr_idx),
        .gnt      (p_wr_gnt_o)
    );

    assign shim_rd_addr_o = p_rd_addr_i[rd_idx];
    assign shim_rd_blen_o = p_rd_blen_i[rd_idx];
    assign shim_rd_size_o = p_rd_size_i[rd_idx];
    assign shim_rd_lock_o = p_rd_lock_i[rd_idx];
    assign shim_rd_id_o   = {rd_idx, p_rd_id_i[rd_idx]};

    assign shim_wr_addr_o = p_wr_addr_i[wr_idx];
    assign shim_wr_data_o = p_wr_data_i[wr_idx];
    assign shim_wr_user_o = p_wr_user_i[wr_idx];
    assign shim_wr_be_o   = p_wr_be_i[wr_idx];
    assign shim_wr_blen_o = p_wr_blen_i[wr_idx];
    assign shim_wr_size_o = p_wr_size_i[wr_idx];
    assign shim_wr_lock_o = p_wr_lock_i[wr_idx];
    assign shim_wr_atop_o = p_wr_atop_i[wr_idx];
    assign shim_wr_id_o   = {wr_idx, p_wr_id_i[wr_idx]};

    assign rd_tag = shim_rd_id_i[AxiIdWidth-1 -: PW];
    assign wr_tag = shim_wr_id_i[AxiIdWidth-1 -: PW];

    // Route by tag; a tag with no matching port is accepted and discarded.
    always_comb begin
        p_rd_valid_o  = '0;
        p_wr_valid_o  = '0;
        shim_rd_rdy_o = 1'b1;
        shim_wr_rdy_o = 1'b1;
        for (int unsigned i = 0; i < NumPorts; i++) begin
            if (32'(rd_tag) == i) begin
                p_rd_valid_o[i] = shim_rd_valid_i;
                shim_rd_rdy_o   = p_rd_rdy_i[i];
            end
            if (32'(wr_tag) == i) begin
                p_wr_valid_o[i] = shim_wr_valid_i;
                shim_wr_rdy_o   = p_wr_rdy_i[i];
            end
        end
    end

    assign p_rd_data_o   = shim_rd_data_i;
    assign p_rd_user_o   = shim_rd_user_i;
    assign p_rd_last_o   = {NumPorts{shim_rd_last_i}};
    assign p_rd_exokay_o = {NumPorts{shim_rd_exokay_i}};
    assign p_rd_id_o     = shim_rd_id_i[IW-1:0];
    assign p_wr_exokay_o = {NumPorts{shim_wr_exokay_i}};
    assign p_wr_id_o     = shim_wr_id_i[IW-1:0];
endmodule

// File: tb/tb_axi_shim_arbiter.sv
// Directed bench for axi_shim_arbiter: arbitration order, grant lock, ID tagging, response routing, reset.

module tb_axi_shim_arbiter;
    localparam int unsigned N = 3, NW = 4, IDW = 4, UW = 64, BW = 2, IW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]                 p_rd_req = '0, p_rd_gnt, p_rd_lock = '0, p_rd_rdy = '0;
    logic [N-1:0]                 p_rd_valid, p_rd_last, p_rd_exokay;
    logic [N-1:0][63:0]           p_rd_addr;
    logic [N-1:0][BW-1:0]         p_rd_blen;
    logic [N-1:0][1:0]            p_rd_size = '0;
    logic [N-1:0][IW-1:0]         p_rd_id;
    logic [63:0]                  p_rd_data;
    logic [UW-1:0]                p_rd_user;
    logic [IW-1:0]                p_rd_rid;
    logic [N-1:0]                 p_wr_req = '0, p_wr_gnt, p_wr_lock = '0, p_wr_rdy = '0;
    logic [N-1:0]                 p_wr_valid, p_wr_exokay;
    logic [N-1:0][63:0]           p_wr_addr;
    logic [N-1:0][NW-1:0][63:0]   p_wr_data = '0;
    logic [N-1:0][NW-1:0][UW-1:0] p_wr_user = '0;
    logic [N-1:0][NW-1:0][7:0]    p_wr_be = '0;
    logic [N-1:0][BW-1:0]         p_wr_blen;
    logic [N-1:0][1:0]            p_wr_size = '0;
    logic [N-1:0][IW-1:0]         p_wr_id;
    logic [N-1:0][5:0]            p_wr_atop = '0;
    logic [IW-1:0]                p_wr_bid;

    logic             s_rd_req, s_rd_gnt = 1'b0, s_rd_lock, s_rd_rdy;
    logic [63:0]      s_rd_addr;
    logic [BW-1:0]    s_rd_blen;
    logic [1:0]       s_rd_size;
    logic [IDW-1:0]   s_rd_id, s_rd_rid = '0;
    logic             s_rd_valid = 1'b0, s_rd_last = 1'b0, s_rd_exokay = 1'b0;
    logic [63:0]      s_rd_data = '0;
    logic [UW-1:0]    s_rd_user = '0;
    logic             s_wr_req, s_wr_gnt = 1'b0, s_wr_lock, s_wr_rdy;
    logic [63:0]      s_wr_addr;
    logic [NW-1:0][63:0] s_wr_data;
    logic [NW-1:0][UW-1:0] s_wr_user;
    logic [NW-1:0][7:0] s_wr_be;
    logic [BW-1:0]    s_wr_blen;
    logic [1:0]       s_wr_size;
    logic [IDW-1:0]   s_wr_id, s_wr_bid = '0;
    logic [5:0]       s_wr_atop;
    logic             s_wr_valid = 1'b0, s_wr_exokay = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    logic [2:0] exp_g  [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    logic [3:0] exp_id [4] = '{4'h3, 4'h6, 4'h9, 4'h3};

    axi_shim_arbiter #(.NumPorts(N), .AxiNumWords(NW), .AxiIdWidth(IDW), .AxiUserWidth(UW)) u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .p_rd_req_i(p_rd_req), .p_rd_gnt_o(p_rd_gnt), .p_rd_addr_i(p_rd_addr),
        .p_rd_blen_i(p_rd_blen), .p_rd_size_i(p_rd_size), .p_rd_id_i(p_rd_id),
        .p_rd_lock_i(p_rd_lock), .p_rd_rdy_i(p_rd_rdy), .p_rd_valid_o(p_rd_valid),
        .p_rd_last_o(p_rd_last), .p_rd_exokay_o(p_rd_exokay), .p_rd_data_o(p_rd_data),
        .p_rd_user_o(p_rd_user), .p_rd_id_o(p_rd_rid),
        .p_wr_req_i(p_wr_req), .p_wr_gnt_o(p_wr_gnt), .p_wr_addr_i(p_wr_addr),
        .p_wr_data_i(p_wr_data), .p_wr_user_i(p_wr_user), .p_wr_be_i(p_wr_be),
        .p_wr_blen_i(p_wr_blen), .p_wr_size_i(p_wr_size), .p_wr_id_i(p_wr_id),
        .p_wr_lock_i(p_wr_lock), .p_wr_atop_i(p_wr_atop), .p_wr_rdy_i(p_wr_rdy),
        .p_wr_valid_o(p_wr_valid), .p_wr_exokay_o(p_wr_exokay), .p_wr_id_o(p_wr_bid),
        .shim_rd_req_o(s_rd_req), .shim_rd_gnt_i(s_rd_gnt), .shim_rd_addr_o(s_rd_addr),
        .shim_rd_blen_o(s_rd_blen), .shim_rd_size_o(s_rd_size), .shim_rd_id_o(s_rd_id),
        .shim_rd_lock_o(s_rd_lock), .shim_rd_rdy_o(s_rd_rdy), .shim_rd_valid_i(s_rd_valid),
        .shim_rd_last_i(s_rd_last), .shim_rd_exokay_i(s_rd_exokay), .shim_rd_data_i(s_rd_data),
        .shim_rd_user_i(s_rd_user), .shim_rd_id_i(s_rd_rid),
        .shim_wr_req_o(s_wr_req), .shim_wr_gnt_i(s_wr_gnt), .shim_wr_addr_o(s_wr_addr),
        .shim_wr_data_o(s_wr_data), .shim_wr_user_o(s_wr_user), .shim_wr_be_o(s_wr_be),
        .shim_wr_blen_o(s_wr_blen), .shim_wr_size_o(s_wr_size), .shim_wr_id_o(s_wr_id),
        .shim_wr_lock_o(s_wr_lock), .shim_wr_atop_o(s_wr_atop), .shim_wr_rdy_o(s_wr_rdy),
        .shim_wr_valid_i(s_wr_valid), .shim_wr_exokay_i(s_wr_exokay), .shim_wr_id_i(s_wr_bid)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle invariants: one grant per direction, owner keeps requesting while locked.
    always @(negedge clk) begin
        if (rst_n) begin
            check("rd_onehot", 64'($countones(p_rd_gnt) <= 1), 64'd1);
            check("wr_onehot", 64'($countones(p_wr_gnt) <= 1), 64'd1);
            if (u_dut.u_rd_arb.locked) check("rd_hold", 64'(p_rd_req[u_dut.u_rd_arb.sel_q]), 64'd1);
            if (u_dut.u_wr_arb.locked) check("wr_hold", 64'(p_wr_req[u_dut.u_wr_arb.sel_q]), 64'd1);
        end
    end

    initial begin
        for (int i = 0; i < int'(N); i++) begin
            p_rd_addr[i] = 64'h1000 * 64'(i + 1);
            p_wr_addr[i] = 64'h2000 * 64'(i + 1);
            p_rd_blen[i] = BW'(i);
            p_wr_blen[i] = BW'(i);
            p_rd_id[i]   = IW'(i);
            p_wr_id[i]   = IW'(3 - i);
        end

        // reset state
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("rst_rd_req", 64'(s_rd_req), 64'd0);
        check("rst_wr_req", 64'(s_wr_req), 64'd0);
        check("rst_rd_gnt", 64'(p_rd_gnt), 64'd0);
        check("rst_wr_gnt", 64'(p_wr_gnt), 64'd0);
        check("rst_rr", 64'(u_dut.u_rd_arb.rr_q), 64'd0);

        // single read from port 1, granted immediately
        step();
        p_rd_req = 3'b010; s_rd_gnt = 1'b1;
        #1;
        check("rd1_req", 64'(s_rd_req), 64'd1);
        check("rd1_id", 64'(s_rd_id), 64'h5);
        check("rd1_gnt", 64'(p_rd_gnt), 64'b010);
        check("rd1_addr", s_rd_addr, 64'h2000);
        step();
        p_rd_req = '0; s_rd_gnt = 1'b0;
        #1;
        check("rd1_rr", 64'(u_dut.u_rd_arb.rr_q), 64'd2);
        check("rd1_idle", 64'(s_rd_req), 64'd0);

        // R routing, backpressure and out-of-range tag
        s_rd_valid = 1'b1; s_rd_rid = 4'h5; p_rd_rdy = 3'b010;
        #1;
        check("r_valid", 64'(p_rd_valid), 64'b010);
        check("r_id", 64'(p_rd_rid), 64'd1);
        check("r_rdy", 64'(s_rd_rdy), 64'd1);
        step();
        p_rd_rdy = 3'b101;
        #1;
        check("r_rdy_bp", 64'(s_rd_rdy), 64'd0);
        step();
        s_rd_rid = 4'hE; p_rd_rdy = '0;
        #1;
        check("r_tag3_rdy", 64'(s_rd_rdy), 64'd1);
        check("r_tag3_valid", 64'(p_rd_valid), 64'd0);
        step();
        s_rd_valid = 1'b0;

        // B routing
        s_wr_valid = 1'b1; s_wr_bid = 4'h9; p_wr_rdy = 3'b100;
        #1;
        check("b_valid", 64'(p_wr_valid), 64'b100);
        check("b_id", 64'(p_wr_bid), 64'd1);
        check("b_rdy", 64'(s_wr_rdy), 64'd1);
        step();
        p_wr_rdy = 3'b011;
        #1;
        check("b_rdy_bp", 64'(s_wr_rdy), 64'd0);
        step();
        s_wr_valid = 1'b0; p_wr_rdy = '0;

        // all ports write continuously: 0,1,2,0
        p_wr_req = 3'b111; s_wr_gnt = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("wr_rr_gnt", 64'(p_wr_gnt), 64'(exp_g[k]));
            check("wr_rr_id", 64'(s_wr_id), 64'(exp_id[k]));
            step();
        end

        // port 0 burst stalled two cycles, port 2 arrives mid-lock
        p_wr_req = 3'b001; s_wr_gnt = 1'b0; p_wr_blen[0] = 2'd3;
        #1;
        check("wlk_addr0", s_wr_addr, 64'h2000);
        check("wlk_blen0", 64'(s_wr_blen), 64'd3);
        check("wlk_gnt0", 64'(p_wr_gnt), 64'd0);
        step();
        p_wr_req = 3'b101;
        #1;
        check("wlk_addr1", s_wr_addr, 64'h2000);
        check("wlk_id1", 64'(s_wr_id), 64'h3);
        check("wlk_gnt1", 64'(p_wr_gnt), 64'd0);
        step();
        s_wr_gnt = 1'b1;
        #1;
        check("wlk_gnt2", 64'(p_wr_gnt), 64'b001);
        check("wlk_addr2", s_wr_addr, 64'h2000);
        step();
        p_wr_req = 3'b100;
        #1;
        check("wlk_gnt3", 64'(p_wr_gnt), 64'b100);
        check("wlk_addr3", s_wr_addr, 64'h6000);
        step();
        p_wr_req = '0; s_wr_gnt = 1'b0;

        // read to port 2 held off 4 cycles while port 0 also requests
        p_rd_req = 3'b101;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rlk_addr", s_rd_addr, 64'h3000);
            check("rlk_gnt", 64'(p_rd_gnt), 64'd0);
            step();
        end
        s_rd_gnt = 1'b1;
        #1;
        check("rlk_gnt2", 64'(p_rd_gnt), 64'b100);
        check("rlk_id2", 64'(s_rd_id), 64'hA);
        step();
        #1;
        check("rlk_gnt0", 64'(p_rd_gnt), 64'b001);
        check("rlk_addr0", s_rd_addr, 64'h1000);
        check("rlk_id0", 64'(s_rd_id), 64'h0);
        step();
        p_rd_req = '0; s_rd_gnt = 1'b0;

        // reset while locked
        p_rd_req = 3'b010;
        #1;
        check("rst_lk_req", 64'(s_rd_req), 64'd1);
        step();
        check("rst_lk_locked", 64'(u_dut.u_rd_arb.locked), 64'd1);
        check("rst_lk_sel", 64'(u_dut.u_rd_arb.sel_q), 64'd1);
        rst_n = 1'b0; p_rd_req = '0;
        #1;
        check("rst_lk_idle", 64'(u_dut.u_rd_arb.locked), 64'd0);
        check("rst_lk_rr", 64'(u_dut.u_rd_arb.rr_q), 64'd0);
        check("rst_lk_gnt", 64'(p_rd_gnt), 64'd0);
        step();
        rst_n = 1'b1; p_rd_req = 3'b011; s_rd_gnt = 1'b1;
        #1;
        check("rst_lk_first", 64'(p_rd_gnt), 64'b001);
        step();
        p_rd_req = '0; s_rd_gnt = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
